// File: rtl/dot_accumulator_pkg.sv
// Shared constants and FSM state encoding for the dot-product accumulation stage.
package dot_pkg;

   localparam int DATA_W        = 16;
   localparam int TERMS_DEFAULT = 4;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/dot_accumulator_if.sv
// Term-in / result-out handshake bundle for dot_accumulator.
interface dot_accumulator_if;

   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_term;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_ovf;

   modport master (
      output in_valid, in_term, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf
   );

   modport slave (
      input  in_valid, in_term, out_ready,
      output in_ready, out_valid, out_sum, out_ovf
   );

endinterface

// File: rtl/dot_accumulator_adder.sv
// FA_sixteen: the shared 16-bit ripple-carry adder (one full adder per bit).
module FA_sixteen
   import dot_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   output logic [DATA_W-1:0] sum,
   output logic              cout
);

   logic carry_s;

   // Ripple the carry LSB to MSB through one full adder per bit.
   always_comb begin
      carry_s = cin;
      sum     = {DATA_W{1'b0}};
      for (int i = 0; i < DATA_W; i++) begin
         sum[i]  = a[i] ^ b[i] ^ carry_s;
         carry_s = (a[i] & b[i]) | (carry_s & (a[i] ^ b[i]));
      end
      cout = carry_s;
   end

endmodule

// File: rtl/dot_accumulator.sv
// Sums each group of TERMS 16-bit terms (mod 2^16) and holds the result for a handshake.
// Optional sticky carry flag on out_ovf when DOT_ACC_OVF_EN is defined.
module dot_accumulator
   import dot_pkg::*;
#(
   parameter int TERMS = TERMS_DEFAULT
)
(
   input logic              clk,
   input logic              rst_n,
   input logic              clr,
   dot_accumulator_if.slave bus
);

   localparam int               CNT_W    = (TERMS > 1) ? $clog2(TERMS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMS - 1);
   localparam logic [0:0]       ST_ACCUM = ACCUM;
   localparam logic [0:0]       ST_HOLD  = HOLD;

   logic [0:0]        state_r;
   logic [DATA_W-1:0] acc_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [DATA_W-1:0] a_op_s;
   logic [DATA_W-1:0] sum_s;
   logic              accept_s;

   // Adder operand select and term-accept decode.
   always_comb begin
      if (cnt_r == {CNT_W{1'b0}}) begin
         a_op_s = {DATA_W{1'b0}};
      end else begin
         a_op_s = acc_r;
      end
      accept_s = bus.in_valid & (state_r == ST_ACCUM) & ~clr;
   end

`ifdef DOT_ACC_OVF_EN
   logic carry_s;
   logic ovf_r;

   FA_sixteen u_adder (
      .a    (a_op_s),
      .b    (bus.in_term),
      .cin  (1'b0),
      .sum  (sum_s),
      .cout (carry_s)
   );

   // Sticky carry-out flag for the group in flight; cleared when the result leaves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if (clr) begin
         ovf_r <= 1'b0;
      end else if ((state_r == ST_HOLD) && bus.out_ready) begin
         ovf_r <= 1'b0;
      end else if (accept_s) begin
         ovf_r <= ovf_r | carry_s;
      end
   end

   assign bus.out_ovf = ovf_r;
`else
   FA_sixteen u_adder (
      .a    (a_op_s),
      .b    (bus.in_term),
      .cin  (1'b0),
      .sum  (sum_s),
      .cout ()
   );

   assign bus.out_ovf = 1'b0;
`endif

   // Group FSM: accumulate TERMS accepted terms, then hold until the consumer takes the sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_ACCUM;
         acc_r   <= {DATA_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else if (clr) begin
         state_r <= ST_ACCUM;
         acc_r   <= {DATA_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_ACCUM: begin
               if (accept_s) begin
                  acc_r <= sum_s;
                  if (cnt_r == CNT_LAST) begin
                     cnt_r   <= {CNT_W{1'b0}};
                     state_r <= ST_HOLD;
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  acc_r   <= {DATA_W{1'b0}};
                  state_r <= ST_ACCUM;
               end
            end
            default: begin
               state_r <= ST_ACCUM;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_r == ST_ACCUM);
   assign bus.out_valid = (state_r == ST_HOLD);
   assign bus.out_sum   = acc_r;

endmodule

// File: doc/dot_accumulator.md
# dot_accumulator

Sequential accumulation stage directly upstream of the matrix-multiply result path. Accepts a stream of 16-bit partial terms, one per handshake. Sums each group of TERMS terms modulo 2^16 through the team's 16-bit ripple adder, then presents the completed dot-product element with a valid/ready handshake. One result is produced per output matrix element.

## Interface
- TERMS, default 4: number of terms summed per result; legal range 2..256.
- CNT_W, default $clog2(TERMS): width of the term counter; derived, never overridden.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- clr, input, 1: synchronous abort; discards the partial sum or the held result.
- in_valid, input, 1: in_term is valid this cycle.
- in_ready, output, 1: block can accept a term this cycle.
- in_term, input, 16: unsigned term to add.
- out_valid, output, 1: out_sum holds a completed result.
- out_ready, input, 1: consumer takes the result this cycle.
- out_sum, output, 16: completed sum, modulo 2^16.
- out_ovf, output, 1: sticky flag; at least one carry out of bit 15 occurred during this result. Only present when DOT_ACC_OVF_EN is defined; otherwise tied to 0.

## Operation
- Two-state FSM:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Registers:
  - acc[15:0]
  - cnt[CNT_W-1:0]
  - ovf
- ACCUM, term accepted (in_valid & in_ready):
  - If cnt==0: acc <= 0 + in_term.
  - Otherwise: acc <= acc + in_term.
  - The adder's carry-in is always 0.
  - cnt increments.
  - When the accepted term is term TERMS-1: cnt <= 0 and the FSM enters HOLD.
- HOLD:
  - out_sum = acc.
  - When out_ready: acc <= 0, ovf <= 0, and the FSM returns to ACCUM.
- Arithmetic is unsigned and wraps modulo 2^16; no saturation.
- The adder's carry out of bit 15 feeds only ovf.
- clr:
  - Highest priority.
  - In any state: acc <= 0, cnt <= 0, ovf <= 0, FSM <= ACCUM.
  - A term presented with clr high is dropped, even though in_ready is 1.
  - A held result is discarded and never handshaken.
- in_valid in HOLD is ignored (in_ready=0). Upstream must hold in_term stable until accepted.
- out_ready while out_valid=0 has no effect.

## Timing
- Reset values:
  - state=ACCUM, acc=0, cnt=0, ovf=0.
  - in_ready=1, out_valid=0, out_sum=0, out_ovf=0.
- Latency: out_valid rises the cycle after the final term is accepted.
- in_ready returns to 1 the cycle after the output handshake.
- Throughput: at most one result per TERMS+1 cycles; no output bypass.
- The adder is a combinational ripple path. acc feeds the adder and the adder feeds acc, giving a single-cycle critical path of 16 carry stages.
- All outputs are driven directly from registers or the FSM state; no combinational input-to-output paths.
- Reset asserted mid-group or mid-HOLD: immediate return to reset values; no partial result emitted.

## Configuration
- DOT_ACC_OVF_EN defined:
  - ovf is set by any adder carry-out from an accepted term in the current group.
  - ovf is registered and presented on out_ovf alongside out_sum in HOLD.
  - ovf clears on output handshake, clr, or reset.
- DOT_ACC_OVF_EN undefined:
  - No ovf register.
  - out_ovf=0 constantly.
  - The carry-out is left unconnected.

## Structure
- Shared package dot_pkg:
  - DATA_W=16.
  - The FSM state enum {ACCUM, HOLD}.
  - Default TERMS constant.
- One sub-module: the existing 16-bit ripple adder FA_sixteen, instantiated once.
  - A operand: acc, or 0 when cnt==0.
  - B operand: in_term.
  - Its carry-out is exposed for DOT_ACC_OVF_EN use.
- The FSM, counter and registers live in dot_accumulator itself.

## Test plan
- Basic sum: TERMS=4, terms 1,2,3,4 back-to-back, out_ready=1. out_valid high one cycle after the 4th accept, out_sum=10, out_ovf=0, in_ready low for exactly one cycle.
- Wrap/overflow: terms 0xFFFF,0x0002,0,0. out_sum=0x0001; out_ovf=1 when DOT_ACC_OVF_EN is defined, 0 when it is undefined. The next group 5,5,5,5 gives out_sum=20 with out_ovf=0.
- Backpressure: out_ready=0 for 5 cycles after the result. out_valid and out_sum stay stable, in_ready stays 0, and in_valid with in_term=0x1234 is not accepted. After out_ready=1, the next group sums correctly from 0.
- Clear mid-group: accept 7 then 9, assert clr together with in_valid (in_term=100). Then 1,1,1,1 gives out_sum=4; the dropped term is not included.
- Clear in HOLD: result 10 held, clr asserted with out_ready=0. out_valid drops the next cycle, and that result is never delivered.
- Async reset: assert rst_n low mid-group, between clock edges. All outputs go to reset values immediately, with in_ready=1. After release, 2,2,2,2 gives out_sum=8.
